mux_bus_arbiter: RTL and testbench

- Two-requester round-robin arbiter for the shared 16-bit 2:1 select datapath (a/b inputs, sel, o output).
- Accepts words from requester A and requester B over valid/ready handshakes.
- Drives the datapath select and registers the selected word into a single-entry output stage with its own valid/ready handshake.
- Sits between two producer units and one downstream consumer; bounds starvation with a per-grant burst limit.

---
 rtl/mux_bus_arbiter.sv | 118 +++++++++++
 tb/tb_mux_bus_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_bus_arbiter.sv
// Two-requester round-robin arbiter with burst limit feeding a
// single-entry registered output stage for the shared 2:1 datapath.
module mux_bus_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             o_ready,
  output logic [3:0]       grant_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_A,
    GNT_B
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt_nxt;
  logic       last_b;
  logic       last_b_nxt;
  logic       load_en;
  logic       xfer;

  assign load_en = !o_valid || o_ready;
  assign sel     = (state == GNT_B);
  assign a_ready = (state == GNT_A) && load_en;
  assign b_ready = (state == GNT_B) && load_en;
  assign xfer    = (a_valid && a_ready) || (b_valid && b_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_cnt <= '0;
      last_b    <= 1'b1;
    end else begin
      state     <= state_nxt;
      grant_cnt <= cnt_nxt;
      last_b    <= last_b_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = grant_cnt;
    last_b_nxt = last_b;
    case (state)
      IDLE: begin
        if (a_valid && (!b_valid || last_b))
          state_nxt = GNT_A;
        else if (b_valid)
          state_nxt = GNT_B;
      end
      GNT_A: begin
        if (xfer) begin
          if (grant_cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (b_valid) begin
              state_nxt  = GNT_B;
              last_b_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = grant_cnt + 4'd1;
          end
        end else if (!a_valid) begin
          state_nxt  = b_valid ? GNT_B : IDLE;
          cnt_nxt    = '0;
          last_b_nxt = 1'b0;
        end
      end
      GNT_B: begin
        if (xfer) begin
          if (grant_cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (a_valid) begin
              state_nxt  = GNT_A;
              last_b_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = grant_cnt + 4'd1;
          end
        end else if (!b_valid) begin
          state_nxt  = a_valid ? GNT_A : IDLE;
          cnt_nxt    = '0;
          last_b_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a stalled word just sits here; drain and reload may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_data  <= sel ? b_data : a_data;
    end else if (o_ready && o_valid) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Randomized bench: cycle model of the arbitration rules plus an
// output queue; every DUT output is checked each cycle.
module tb_mux_bus_arbiter;

  localparam int W  = 16;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a_valid = 1'b0;
  logic [W-1:0] a_data = '0;
  logic         a_ready;
  logic         b_valid = 1'b0;
  logic [W-1:0] b_data = '0;
  logic         b_ready;
  logic         sel;
  logic         o_valid;
  logic [W-1:0] o_data;
  logic         o_ready = 1'b0;
  logic [3:0]   grant_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model: g 0=none 1=A 2=B, last = who was served last
  int           g;
  int           last;
  int           cnt;
  logic [W-1:0] outq[$];
  logic [W-1:0] mdata;
  bit           a_hs;
  bit           b_hs;

  mux_bus_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .o_valid(o_valid), .o_data(o_data),
    .o_ready(o_ready), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic mdl_reset();
    g = 0; last = 2; cnt = 0; mdata = '0;
    outq.delete();
    a_hs = 0; b_hs = 0;
  endtask

  function automatic bit m_load();
    return (outq.size() == 0) || o_ready;
  endfunction

  task automatic check_all(string ph);
    bit ld;
    ld = m_load();
    chk({ph, ".a_ready"}, 32'(a_ready), 32'(g == 1 && ld));
    chk({ph, ".b_ready"}, 32'(b_ready), 32'(g == 2 && ld));
    chk({ph, ".sel"}, 32'(sel), 32'(g == 2));
    chk({ph, ".o_valid"}, 32'(o_valid), 32'(outq.size() != 0));
    chk({ph, ".o_data"}, 32'(o_data), 32'(mdata));
    chk({ph, ".grant_cnt"}, 32'(grant_cnt), 32'(cnt));
  endtask

  task automatic mdl_step();
    bit ld;
    int taken;
    bit mine;
    bit other;
    ld = m_load();
    taken = 0;
    if (g == 1 && a_valid && ld) taken = 1;
    if (g == 2 && b_valid && ld) taken = 2;
    a_hs = (taken == 1);
    b_hs = (taken == 2);
    if (o_ready && outq.size() != 0) void'(outq.pop_front());
    if (taken != 0) begin
      mdata = (taken == 1) ? a_data : b_data;
      outq.push_back(mdata);
    end
    if (g == 0) begin
      if (a_valid && b_valid) g = (last == 1) ? 2 : 1;
      else if (a_valid) g = 1;
      else if (b_valid) g = 2;
    end else begin
      mine  = (g == 1) ? a_valid : b_valid;
      other = (g == 1) ? b_valid : a_valid;
      if (taken != 0) begin
        if (cnt == MB - 1) begin
          cnt = 0;
          if (other) begin
            last = g;
            g = 3 - g;
          end
        end else begin
          cnt++;
        end
      end else if (!mine) begin
        last = g;
        g = other ? 3 - g : 0;
        cnt = 0;
      end
    end
  endtask

  // requesters never drop valid before their handshake
  task automatic drive(int pa, int pb, int po);
    if (a_hs) begin
      a_valid = ($urandom_range(99) < pa);
      a_data  = W'($urandom);
    end else if (!a_valid && $urandom_range(99) < pa) begin
      a_valid = 1'b1;
      a_data  = W'($urandom);
    end
    if (b_hs) begin
      b_valid = ($urandom_range(99) < pb);
      b_data  = W'($urandom);
    end else if (!b_valid && $urandom_range(99) < pb) begin
      b_valid = 1'b1;
      b_data  = W'($urandom);
    end
    o_ready = ($urandom_range(99) < po);
  endtask

  initial begin
    int pa;
    int pb;
    int po;
    bit rel;
    mdl_reset();
    rel = 0;
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (rel) begin
        rst_n = 1'b1;
        rel = 0;
      end
      if (cyc < 200) begin
        pa = 50; pb = 50; po = 70;
      end else if (cyc < 300) begin
        pa = 100; pb = 100; po = 100;
      end else if (cyc < 400) begin
        pa = 100; pb = 0; po = 100;
      end else if (cyc < 500) begin
        pa = 80; pb = 80; po = 30;
      end else begin
        pa = 60; pb = 40; po = 80;
      end
      drive(pa, pb, po);
      #1 check_all("run");
      mdl_step();
      if (cyc == 250 || cyc == 450) begin
        #1 rst_n = 1'b0;
        mdl_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1 check_all("async_rst");
        rel = 1;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
